// File: rtl/wb_unit.sv
// Writeback unit: arbitrates load responses and ALU results onto the regfile write port,
// with a one-entry ALU skid buffer. Define WB_BYPASS_EN to add the two read-port bypass taps.
module wb_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [2:0]        mem_funct3,
    input  logic [1:0]        mem_addr_lo,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [REG_AW-1:0] rd,
    output logic              wEn,
    output logic [XLEN-1:0]   data,
    output logic              fmt_err
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_AW-1:0] byp_rs1,
    input  logic [REG_AW-1:0] byp_rs2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [XLEN-1:0]   byp_data1,
    output logic [XLEN-1:0]   byp_data2
`endif
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]        r_state;
    logic [REG_AW-1:0] r_skid_rd;
    logic [XLEN-1:0]   r_skid_data;
    logic              r_wen;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_data;
    logic              r_fmt_err;

    logic              w_alu_acc;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load_data;
    logic              w_load_ok;
    logic              w_sel_valid;
    logic              w_sel_err;
    logic [REG_AW-1:0] w_sel_rd;
    logic [XLEN-1:0]   w_sel_data;
    logic              w_skid_load;
    logic [0:0]        w_next_state;
    logic              w_we;

    assign alu_ready = (r_state == S_EMPTY);
    assign w_alu_acc = alu_valid && alu_ready;

    // Little-endian lanes; LH uses only the upper offset bit to pick the half.
    assign w_byte = mem_rdata[{mem_addr_lo, 3'b000} +: 8];
    assign w_half = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_load_data = '0;
        w_load_ok   = 1'b1;
        case (mem_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b010:  w_load_data = mem_rdata;
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_ok   = 1'b0;
        endcase
    end

    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_err    = 1'b0;
        w_sel_rd     = '0;
        w_sel_data   = '0;
        w_skid_load  = 1'b0;
        w_next_state = r_state;
        if (mem_valid) begin
            w_sel_valid = 1'b1;
            w_sel_err   = !w_load_ok;
            w_sel_rd    = mem_rd;
            w_sel_data  = w_load_data;
            if (w_alu_acc) begin
                w_skid_load  = 1'b1;
                w_next_state = S_FULL;
            end
        end else if (r_state == S_FULL) begin
            w_sel_valid  = 1'b1;
            w_sel_rd     = r_skid_rd;
            w_sel_data   = r_skid_data;
            w_next_state = S_EMPTY;
        end else if (w_alu_acc) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end
    end

    // Writes to x0 and illegal loads still consume the slot but never reach the regfile.
    assign w_we = w_sel_valid && !w_sel_err && (w_sel_rd != '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_EMPTY;
            r_wen     <= 1'b0;
            r_rd      <= '0;
            r_data    <= '0;
            r_fmt_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_wen     <= w_we;
            r_rd      <= w_we ? w_sel_rd : '0;
            r_data    <= w_we ? w_sel_data : '0;
            r_fmt_err <= w_sel_err;
        end
    end

    // NOTE: skid payload is not reset; it is only observed while r_state is FULL.
    always_ff @(posedge clk) begin
        if (w_skid_load) begin
            r_skid_rd   <= alu_rd;
            r_skid_data <= alu_data;
        end
    end

    assign rd      = r_rd;
    assign wEn     = r_wen;
    assign data    = r_data;
    assign fmt_err = r_fmt_err;

`ifdef WB_BYPASS_EN
    assign byp_hit1  = r_wen && (r_rd == byp_rs1) && (r_rd != '0);
    assign byp_hit2  = r_wen && (r_rd == byp_rs2) && (r_rd != '0);
    assign byp_data1 = byp_hit1 ? r_data : '0;
    assign byp_data2 = byp_hit2 ? r_data : '0;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed literal cases plus randomized traffic
// compared every cycle against a queue-based write-port model.
module tb_wb_unit;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic        wEn;
    logic [31:0] data;
    logic        fmt_err;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_rs1;
    logic [4:0]  byp_rs2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
`endif

    wb_unit #(.XLEN(32), .REG_AW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_funct3 (mem_funct3),
        .mem_addr_lo(mem_addr_lo),
        .mem_rdata  (mem_rdata),
        .rd         (rd),
        .wEn        (wEn),
        .data       (data),
        .fmt_err    (fmt_err)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs1    (byp_rs1),
        .byp_rs2    (byp_rs2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data1  (byp_data1),
        .byp_data2  (byp_data2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference model: pending ALU results live in a queue; each edge grants the port
    // to the load, else the oldest pending result, else a fresh accepted ALU result.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        pend[$];
    logic        exp_wen   = 1'b0;
    logic [4:0]  exp_rd    = '0;
    logic [31:0] exp_data  = '0;
    logic        exp_err   = 1'b0;
    logic        exp_ready = 1'b1;

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [4:0] r, input logic [31:0] d, input logic legal);
        exp_err  = !legal;
        exp_wen  = legal && (r != 0);
        exp_rd   = exp_wen ? r : 5'd0;
        exp_data = exp_wen ? d : 32'd0;
    endtask

    always @(posedge clk) begin
        logic acc;
        ent_t e;
        acc = alu_valid && exp_ready;
        exp_wen = 1'b0; exp_rd = '0; exp_data = '0; exp_err = 1'b0;
        if (reset) begin
            pend.delete();
        end else if (mem_valid) begin
            model_write(mem_rd, load_value(mem_funct3, mem_addr_lo, mem_rdata),
                        mem_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            if (acc) begin
                e.rd = alu_rd; e.d = alu_data;
                pend.push_back(e);
            end
        end else if (pend.size() != 0) begin
            e = pend.pop_front();
            model_write(e.rd, e.d, 1'b1);
        end else if (acc) begin
            model_write(alu_rd, alu_data, 1'b1);
        end
        exp_ready = (pend.size() == 0);
    end

    // Compare process: a little after each falling edge, outputs and inputs are both settled.
    always begin
        @(negedge clk);
        #1;
        check("m_wEn", {31'd0, wEn}, {31'd0, exp_wen});
        check("m_rd", {27'd0, rd}, {27'd0, exp_rd});
        check("m_data", data, exp_data);
        check("m_fmt_err", {31'd0, fmt_err}, {31'd0, exp_err});
        check("m_alu_ready", {31'd0, alu_ready}, {31'd0, exp_ready});
`ifdef WB_BYPASS_EN
        begin
            logic h1, h2;
            h1 = exp_wen && (exp_rd == byp_rs1) && (exp_rd != 0);
            h2 = exp_wen && (exp_rd == byp_rs2) && (exp_rd != 0);
            check("m_byp_hit1", {31'd0, byp_hit1}, {31'd0, h1});
            check("m_byp_hit2", {31'd0, byp_hit2}, {31'd0, h2});
            check("m_byp_data1", byp_data1, h1 ? exp_data : 32'd0);
            check("m_byp_data2", byp_data2, h2 ? exp_data : 32'd0);
        end
`endif
    end

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_funct3 = '0; mem_addr_lo = '0; mem_rdata = '0;
`ifdef WB_BYPASS_EN
        byp_rs1 = '0; byp_rs2 = '0;
`endif
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] w);
        mem_valid = 1'b1; mem_rd = r; mem_funct3 = f3; mem_addr_lo = off; mem_rdata = w;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = r; alu_data = d;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        check("rst_wEn", {31'd0, wEn}, 32'd0);
        check("rst_rd", {27'd0, rd}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_fmt_err", {31'd0, fmt_err}, 32'd0);
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);

        reset = 1'b0;
        alu(5'd1, 32'd2);
        step();
        check("alu_wEn", {31'd0, wEn}, 32'd1);
        check("alu_rd", {27'd0, rd}, 32'd1);
        check("alu_data", data, 32'd2);
        check("alu_ready_kept", {31'd0, alu_ready}, 32'd1);

        idle();
        load(5'd3, 3'b010, 2'd0, 32'h0000_0008);
        alu(5'd4, 32'd16);
        step();
        idle();
        check("coll_load_rd", {27'd0, rd}, 32'd3);
        check("coll_load_data", data, 32'd8);
        check("coll_ready_low", {31'd0, alu_ready}, 32'd0);
        step();
        check("coll_skid_rd", {27'd0, rd}, 32'd4);
        check("coll_skid_data", data, 32'd16);
        check("coll_skid_wEn", {31'd0, wEn}, 32'd1);

        load(5'd6, 3'b000, 2'd3, 32'h80FF_7F01); step();
        check("lb_off3", data, 32'hFFFF_FF80);
        load(5'd6, 3'b100, 2'd2, 32'h80FF_7F01); step();
        check("lbu_off2", data, 32'h0000_00FF);
        load(5'd6, 3'b001, 2'd2, 32'h80FF_7F01); step();
        check("lh_off2", data, 32'hFFFF_80FF);
        load(5'd6, 3'b101, 2'd1, 32'h80FF_7F01); step();
        check("lhu_off1", data, 32'h0000_7F01);

        idle();
        alu(5'd0, 32'd32); step();
        check("x0_wEn", {31'd0, wEn}, 32'd0);
        check("x0_rd", {27'd0, rd}, 32'd0);
        check("x0_data", data, 32'd0);
        idle();
        load(5'd9, 3'b011, 2'd0, 32'h1234_5678); step();
        check("bad_f3_wEn", {31'd0, wEn}, 32'd0);
        check("bad_f3_err", {31'd0, fmt_err}, 32'd1);
        idle(); step();
        check("bad_f3_err_pulse", {31'd0, fmt_err}, 32'd0);

        load(5'd7, 3'b010, 2'd0, 32'h0000_0077);
        alu(5'd8, 32'h0000_0088);
        step();
        check("full_ready_low", {31'd0, alu_ready}, 32'd0);
        idle();
        reset = 1'b1;
        load(5'd10, 3'b010, 2'd0, 32'h0000_00AA);
        step();
        check("rst_mid_wEn", {31'd0, wEn}, 32'd0);
        check("rst_mid_ready", {31'd0, alu_ready}, 32'd1);
        reset = 1'b0;
        idle(); step();
        check("skid_dropped_wEn", {31'd0, wEn}, 32'd0);

`ifdef WB_BYPASS_EN
        alu(5'd5, 32'd32);
        byp_rs1 = 5'd5; byp_rs2 = 5'd0;
        step();
        check("byp_hit1", {31'd0, byp_hit1}, 32'd1);
        check("byp_data1", byp_data1, 32'd32);
        check("byp_hit2", {31'd0, byp_hit2}, 32'd0);
        idle();
`endif

        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            alu_valid   = $urandom_range(0, 1) == 1;
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            mem_valid   = ($urandom_range(0, 2) == 0);
            mem_rd      = 5'($urandom_range(0, 7));
            mem_funct3  = 3'($urandom_range(0, 7));
            mem_addr_lo = 2'($urandom_range(0, 3));
            mem_rdata   = $urandom;
`ifdef WB_BYPASS_EN
            byp_rs1 = 5'($urandom_range(0, 7));
            byp_rs2 = 5'($urandom_range(0, 7));
`endif
            step();
        end
        reset = 1'b0;
        idle();
        step(); step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
